cpu_multiply: RTL and testbench

Iterative 32x32 integer multiplier used by the CPU execute stage for MUL-class instructions. Operands are captured on a level-held request (i_latch). The 64-bit product is computed over several cycles. Completion is signalled with o_ready, which stays high until the request is withdrawn. Signed and unsigned operation are both supported; the low word goes to o_result and the high word to o_result_hi.

---
 rtl/cpu_multiply.sv | 112 +++++++++++
 tb/tb_cpu_multiply.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cpu_multiply.sv
// Iterative 32x32 multiplier for the execute stage: retires STEP_BITS multiplier
// bits per cycle, signed or unsigned, full 64-bit product held until request drops.
module cpu_multiply #(
  parameter int STEP_BITS = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_latch,
  input  logic        i_signed,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_ready,
  output logic [31:0] o_result,
  output logic [31:0] o_result_hi
);

  localparam int N     = 32 / STEP_BITS;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        mcand, mplier;
  logic               negate;
  logic [63:0]        acc;
  logic [CNT_W-1:0]   count;

  logic               capture, step, finish, release_done;
  logic [31:0]        op1_mag, op2_mag;
  logic [STEP_BITS-1:0] digit;
  logic [5:0]         shift_amt;
  logic [63:0]        partial, acc_sum, product;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    step         = 1'b0;
    finish       = 1'b0;
    release_done = 1'b0;
    case (state)
      IDLE: if (i_latch) begin
        capture    = 1'b1;
        state_next = BUSY;
      end
      BUSY: if (!i_latch) begin
        state_next = IDLE;
      end else begin
        step = 1'b1;
        if (count == CNT_W'(N - 1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: if (!i_latch) begin
        release_done = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Magnitudes are unsigned 32-bit, so 0x80000000 maps exactly to 2^31.
  always_comb begin
    op1_mag   = (i_signed && i_op1[31]) ? (-i_op1) : i_op1;
    op2_mag   = (i_signed && i_op2[31]) ? (-i_op2) : i_op2;
    digit     = mplier[STEP_BITS-1:0];
    shift_amt = 6'(count) * 6'(STEP_BITS);
    partial   = 64'(mcand) * 64'(digit);
    acc_sum   = acc + (partial << shift_amt);
    product   = negate ? (-acc_sum) : acc_sum;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      mcand       <= '0;
      mplier      <= '0;
      negate      <= 1'b0;
      acc         <= '0;
      count       <= '0;
      o_ready     <= 1'b0;
      o_result    <= '0;
      o_result_hi <= '0;
    end else begin
      if (capture) begin
        mcand  <= op1_mag;
        mplier <= op2_mag;
        negate <= i_signed & (i_op1[31] ^ i_op2[31]);
        acc    <= '0;
        count  <= '0;
      end
      if (step) begin
        acc    <= acc_sum;
        mplier <= mplier >> STEP_BITS;
        count  <= count + CNT_W'(1);
      end
      if (finish) begin
        {o_result_hi, o_result} <= product;
        o_ready                 <= 1'b1;
      end
      if (release_done) o_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_multiply.sv
// Directed self-checking bench for cpu_multiply (default STEP_BITS = 4, 8-cycle latency).
module tb_cpu_multiply;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_latch;
  logic        i_signed;
  logic [31:0] i_op1, i_op2;
  logic        o_ready;
  logic [31:0] o_result, o_result_hi;

  int checks = 0;
  int errors = 0;

  cpu_multiply dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_latch    (i_latch),
    .i_signed   (i_signed),
    .i_op1      (i_op1),
    .i_op2      (i_op2),
    .o_ready    (o_ready),
    .o_result   (o_result),
    .o_result_hi(o_result_hi)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Request an operation, scramble operands after capture, wait (bounded) for
  // o_ready, check latency and product, optionally hold in DONE, then release.
  task automatic do_mul(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int hold);
    int lat;
    i_signed = sgn;
    i_op1    = a;
    i_op2    = b;
    i_latch  = 1'b1;
    tick();
    i_op1 = a ^ 32'h5A5A_1234;
    i_op2 = b + 32'd77;
    lat   = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      lat = i;
      if (o_ready) break;
    end
    check({tag, " latency"}, 64'(lat), 64'd8);
    check({tag, " lo"}, 64'(o_result), 64'(exp_lo));
    check({tag, " hi"}, 64'(o_result_hi), 64'(exp_hi));
    for (int i = 0; i < hold; i++) begin
      i_op1 = i_op1 + 32'd13;
      i_op2 = i_op2 ^ 32'hFFFF_0000;
      tick();
      check({tag, " hold ready"}, 64'(o_ready), 64'd1);
      check({tag, " hold lo"}, 64'(o_result), 64'(exp_lo));
      check({tag, " hold hi"}, 64'(o_result_hi), 64'(exp_hi));
    end
    i_latch = 1'b0;
    tick();
    check({tag, " release ready"}, 64'(o_ready), 64'd0);
    check({tag, " kept lo"}, 64'(o_result), 64'(exp_lo));
  endtask

  initial begin
    int seen_ready;
    i_reset  = 1'b1;
    i_latch  = 1'b0;
    i_signed = 1'b0;
    i_op1    = '0;
    i_op2    = '0;
    #12;
    check("reset ready", 64'(o_ready), 64'd0);
    check("reset lo", 64'(o_result), 64'd0);
    check("reset hi", 64'(o_result_hi), 64'd0);
    i_reset = 1'b0;
    tick();

    do_mul("u111x222", 1'b0, 32'd111, 32'd222, 32'd24642, 32'd0, 0);
    do_mul("u555x666", 1'b0, 32'd555, 32'd666, 32'd369630, 32'd0, 0);
    do_mul("uFFxFF", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    do_mul("sFFxFF", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
    do_mul("s-3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0);
    do_mul("s80x80", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 0);
    do_mul("hold 1000x3000", 1'b0, 32'd1000, 32'd3000, 32'd3000000, 32'd0, 5);

    // Abort by dropping the request mid-BUSY.
    i_signed = 1'b0;
    i_op1    = 32'd9;
    i_op2    = 32'd9;
    i_latch  = 1'b1;
    tick();
    tick();
    tick();
    tick();
    i_latch = 1'b0;
    seen_ready = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_ready) seen_ready = 1;
    end
    check("abort ready", 64'(seen_ready), 64'd0);
    check("abort lo kept", 64'(o_result), 64'd3000000);

    // Abort by reset mid-BUSY.
    i_op1   = 32'd12;
    i_op2   = 32'd12;
    i_latch = 1'b1;
    tick();
    tick();
    tick();
    i_reset = 1'b1;
    i_latch = 1'b0;
    #3;
    i_reset = 1'b0;
    seen_ready = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_ready) seen_ready = 1;
    end
    check("reset abort ready", 64'(seen_ready), 64'd0);
    check("reset abort lo", 64'(o_result), 64'd0);

    do_mul("u2x3", 1'b0, 32'd2, 32'd3, 32'd6, 32'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
